// File: rtl/ram_dual_pkg.sv
// ram_dual_pkg: shared constants and types for the ram_dual memory slice.
//   READ_SYNC / READ_ASYNC : values of the READ_MODE parameter
//   RDW_OLD / RDW_NEW      : values of the RDW_MODE parameter
//   BYTE_W                 : width of one byte lane covered by a write enable bit
//   clr_state_t            : state type of the optional clear sequencer
package ram_dual_pkg;

    localparam int unsigned READ_SYNC  = 0;
    localparam int unsigned READ_ASYNC = 1;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_t;

endpackage

// File: rtl/ram_dual_clear.sv
// ram_dual_clear: power-up/reset clear sequencer for ram_dual.
// Walks every address once after reset, asking the memory to write zero,
// and holds busy high until the last address has been cleared.
// Only instantiated when RAM_DUAL_INIT_CLEAR_EN is defined.
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset; restarts the sequence at address 0
//   busy     : high while the clear walk is in progress
//   clr_we   : zero-write request for clr_addr at the next rising edge
//   clr_addr : address being cleared
module ram_dual_clear
    import ram_dual_pkg::*;
#(
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    clr_state_t state;

    // Sequencer: CLEAR walks 0..DEPTH-1, the edge clearing the last word leaves it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + ADDR_W'(1);
                    if (clr_addr == LAST_ADDR) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end
                end
                READY: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

    // No clearing on reset edges themselves; the walk starts on the first edge after rst falls.
    assign clr_we = busy & ~rst;

endmodule

// File: rtl/ram_dual.sv
// ram_dual: simple dual-port RAM (one write port, one read port, single clock)
// with byte-enabled writes, selectable synchronous/asynchronous read and
// selectable same-address read-during-write behaviour.
//
// Optional feature: define RAM_DUAL_INIT_CLEAR_EN to add a clear sequencer
// that zeroes every word after reset and reports busy while doing so. With the
// macro undefined busy is tied low and memory powers up uninitialised.
//
// Parameters
//   DATA_W    : word width in bits, multiple of 8
//   ADDR_W    : address width, DEPTH = 2**ADDR_W
//   READ_MODE : READ_SYNC (registered rd_data) or READ_ASYNC (combinational rd_data)
//   RDW_MODE  : RDW_OLD or RDW_NEW, same-address read-during-write result (sync read only)
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   wr_en    : write request
//   wr_addr  : write address
//   wr_data  : write data
//   wr_be    : byte enables, bit i covers wr_data[8i+7:8i]
//   rd_en    : read request
//   rd_addr  : read address
//   rd_data  : read data
//   rd_valid : rd_data carries the result of an accepted read
//   busy     : clear in progress, requests ignored
module ram_dual
    import ram_dual_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 3,
    parameter int unsigned READ_MODE = READ_SYNC,
    parameter int unsigned RDW_MODE  = RDW_OLD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/BYTE_W-1:0] wr_be,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     busy
);

    localparam int unsigned BE_W  = DATA_W / BYTE_W;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok;

`ifdef RAM_DUAL_INIT_CLEAR_EN
    ram_dual_clear #(
        .ADDR_W   (ADDR_W)
    ) u_clear (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );
`else
    assign busy     = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    assign wr_ok = wr_en & ~busy;

    // Storage: clear-walk zero writes, otherwise byte-lane masked user writes.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (wr_be[b]) begin
                    mem[wr_addr][b*BYTE_W +: BYTE_W] <= wr_data[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    generate
        if (READ_MODE == READ_ASYNC) begin : g_async
            // Combinational read; a write shows up once the array has been updated.
            assign rd_data  = mem[rd_addr];
            assign rd_valid = rd_en & ~busy;
        end else begin : g_sync
            logic              rd_ok;
            logic [DATA_W-1:0] rd_word;

            assign rd_ok = rd_en & ~busy;

            // Word to capture: the stored word, with write bytes forwarded in new-data mode.
            always_comb begin
                rd_word = mem[rd_addr];
                if ((RDW_MODE == RDW_NEW) && wr_ok && (wr_addr == rd_addr)) begin
                    for (int b = 0; b < int'(BE_W); b++) begin
                        if (wr_be[b]) begin
                            rd_word[b*BYTE_W +: BYTE_W] = wr_data[b*BYTE_W +: BYTE_W];
                        end
                    end
                end
            end

            // Registered read port; rd_data holds between accepted reads.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= rd_ok;
                    if (rd_ok) begin
                        rd_data <= rd_word;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ram_dual.sv
// tb_ram_dual: directed self-checking bench for ram_dual.
// Four instances share one stimulus stream:
//   u_so  : 8-bit,  synchronous read, old-data read-during-write
//   u_sn  : 8-bit,  synchronous read, new-data read-during-write
//   u_w   : 16-bit, synchronous read, new-data read-during-write
//   u_a   : 8-bit,  asynchronous read
// The 8-bit instances see wr_data[7:0] and wr_be[0].
// Define RAM_DUAL_INIT_CLEAR_EN to exercise the clear sequencer.
module tb_ram_dual;
    import ram_dual_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        rd_en;
    logic [2:0]  rd_addr;

    logic [7:0]  so_data, sn_data, a_data;
    logic [15:0] w_data;
    logic        so_valid, sn_valid, w_valid, a_valid;
    logic        so_busy, sn_busy, w_busy, a_busy;
    logic [3:0]  all_busy;

    assign all_busy = {so_busy, sn_busy, w_busy, a_busy};

    int nvec = 0;
    int nerr = 0;

    ram_dual #(.DATA_W(8), .ADDR_W(3), .READ_MODE(READ_SYNC), .RDW_MODE(RDW_OLD)) u_so (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[7:0]),
        .wr_be(wr_be[0:0]), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(so_data),
        .rd_valid(so_valid), .busy(so_busy));

    ram_dual #(.DATA_W(8), .ADDR_W(3), .READ_MODE(READ_SYNC), .RDW_MODE(RDW_NEW)) u_sn (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[7:0]),
        .wr_be(wr_be[0:0]), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(sn_data),
        .rd_valid(sn_valid), .busy(sn_busy));

    ram_dual #(.DATA_W(16), .ADDR_W(3), .READ_MODE(READ_SYNC), .RDW_MODE(RDW_NEW)) u_w (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(w_data),
        .rd_valid(w_valid), .busy(w_busy));

    ram_dual #(.DATA_W(8), .ADDR_W(3), .READ_MODE(READ_ASYNC), .RDW_MODE(RDW_OLD)) u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[7:0]),
        .wr_be(wr_be[0:0]), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_data),
        .rd_valid(a_valid), .busy(a_busy));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_be   = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
    endtask

    task automatic wait_not_busy(output int n);
        n = 0;
        while (so_busy && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        idle();
        rst = 1'b1;
        tick();
        tick();
        nvec++; if (so_valid !== 1'b0) begin nerr++; $display("FAIL reset_so_valid: got %b expected 0", so_valid); end
        nvec++; if (so_data !== 8'h00) begin nerr++; $display("FAIL reset_so_data: got %h expected 00", so_data); end
        nvec++; if (w_data !== 16'h0000) begin nerr++; $display("FAIL reset_w_data: got %h expected 0000", w_data); end
        nvec++; if (w_valid !== 1'b0) begin nerr++; $display("FAIL reset_w_valid: got %b expected 0", w_valid); end
        rst = 1'b0;
`ifdef RAM_DUAL_INIT_CLEAR_EN
        nvec++; if (all_busy !== 4'b1111) begin nerr++; $display("FAIL reset_busy: got %b expected 1111", all_busy); end
        wait_not_busy(n);
        nvec++; if (n != 8) begin nerr++; $display("FAIL reset_busy_len: got %0d expected 8", n); end
`else
        nvec++; if (all_busy !== 4'b0000) begin nerr++; $display("FAIL reset_busy: got %b expected 0000", all_busy); end
`endif
    endtask

    // Write on the first edge after reset, then a single read of the same word.
    task automatic test_basic();
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h005A; wr_be = 2'b11;
        tick();
        nvec++; if (so_valid !== 1'b0) begin nerr++; $display("FAIL basic_no_read_valid: got %b expected 0", so_valid); end
        wr_en = 1'b0; rd_en = 1'b1; rd_addr = 3'd3;
        tick();
        nvec++; if (so_valid !== 1'b1) begin nerr++; $display("FAIL basic_valid: got %b expected 1", so_valid); end
        nvec++; if (so_data !== 8'h5A) begin nerr++; $display("FAIL basic_data: got %h expected 5a", so_data); end
        nvec++; if (w_data !== 16'h005A) begin nerr++; $display("FAIL basic_w_data: got %h expected 005a", w_data); end
        rd_en = 1'b0;
        tick();
        nvec++; if (so_valid !== 1'b0) begin nerr++; $display("FAIL basic_valid_drop: got %b expected 0", so_valid); end
        nvec++; if (so_data !== 8'h5A) begin nerr++; $display("FAIL basic_hold: got %h expected 5a", so_data); end
`ifndef RAM_DUAL_INIT_CLEAR_EN
        nvec++; if (all_busy !== 4'b0000) begin nerr++; $display("FAIL basic_busy: got %b expected 0000", all_busy); end
`endif
    endtask

    task automatic test_byte_enable();
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'hAAAA; wr_be = 2'b11;
        tick();
        wr_data = 16'h1234; wr_be = 2'b01;
        tick();
        wr_en = 1'b0; rd_en = 1'b1; rd_addr = 3'd4;
        tick();
        nvec++; if (w_data !== 16'hAA34) begin nerr++; $display("FAIL be_w_data: got %h expected aa34", w_data); end
        nvec++; if (w_valid !== 1'b1) begin nerr++; $display("FAIL be_w_valid: got %b expected 1", w_valid); end
        nvec++; if (so_data !== 8'h34) begin nerr++; $display("FAIL be_so_data: got %h expected 34", so_data); end
        // All-zero byte enables: no change.
        rd_en = 1'b0; wr_en = 1'b1; wr_data = 16'hFFFF; wr_be = 2'b00;
        tick();
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        nvec++; if (w_data !== 16'hAA34) begin nerr++; $display("FAIL be_noop_w: got %h expected aa34", w_data); end
        nvec++; if (so_data !== 8'h34) begin nerr++; $display("FAIL be_noop_so: got %h expected 34", so_data); end
        rd_en = 1'b0;
    endtask

    task automatic test_rdw();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h1111; wr_be = 2'b11;
        tick();
        wr_data = 16'h2222; rd_en = 1'b1; rd_addr = 3'd2;
        tick();
        nvec++; if (so_data !== 8'h11) begin nerr++; $display("FAIL rdw_old: got %h expected 11", so_data); end
        nvec++; if (sn_data !== 8'h22) begin nerr++; $display("FAIL rdw_new: got %h expected 22", sn_data); end
        nvec++; if (sn_valid !== 1'b1) begin nerr++; $display("FAIL rdw_new_valid: got %b expected 1", sn_valid); end
        nvec++; if (w_data !== 16'h2222) begin nerr++; $display("FAIL rdw_new_w: got %h expected 2222", w_data); end
        // New-data forwarding only replaces the enabled byte.
        wr_data = 16'h3333; wr_be = 2'b10;
        tick();
        nvec++; if (w_data !== 16'h3322) begin nerr++; $display("FAIL rdw_merge_w: got %h expected 3322", w_data); end
        nvec++; if (sn_data !== 8'h22) begin nerr++; $display("FAIL rdw_merge_sn: got %h expected 22", sn_data); end
        wr_en = 1'b0;
        tick();
        nvec++; if (so_data !== 8'h22) begin nerr++; $display("FAIL rdw_after: got %h expected 22", so_data); end
        nvec++; if (w_data !== 16'h3322) begin nerr++; $display("FAIL rdw_after_w: got %h expected 3322", w_data); end
        rd_en = 1'b0;
    endtask

    task automatic test_independent();
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h009C; wr_be = 2'b11;
        rd_en = 1'b1; rd_addr = 3'd3;
        tick();
        nvec++; if (so_data !== 8'h5A) begin nerr++; $display("FAIL indep_rd: got %h expected 5a", so_data); end
        nvec++; if (sn_data !== 8'h5A) begin nerr++; $display("FAIL indep_rd_sn: got %h expected 5a", sn_data); end
        wr_en = 1'b0; rd_addr = 3'd6;
        tick();
        nvec++; if (so_data !== 8'h9C) begin nerr++; $display("FAIL indep_wr: got %h expected 9c", so_data); end
        rd_en = 1'b0;
    endtask

    task automatic test_async();
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h0000; wr_be = 2'b11;
        tick();
        wr_addr = 3'd1; wr_data = 16'h0001;
        tick();
        wr_en = 1'b0; rd_en = 1'b1; rd_addr = 3'd0;
        #2;
        nvec++; if (a_data !== 8'h00) begin nerr++; $display("FAIL async_addr0: got %h expected 00", a_data); end
        nvec++; if (a_valid !== 1'b1) begin nerr++; $display("FAIL async_valid: got %b expected 1", a_valid); end
        rd_addr = 3'd1;
        #2;
        nvec++; if (a_data !== 8'h01) begin nerr++; $display("FAIL async_addr1: got %h expected 01", a_data); end
        rd_en = 1'b0;
        #1;
        nvec++; if (a_valid !== 1'b0) begin nerr++; $display("FAIL async_valid_low: got %b expected 0", a_valid); end
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h0066;
        tick();
        wr_data = 16'h0077; rd_addr = 3'd5;
        #1;
        nvec++; if (a_data !== 8'h66) begin nerr++; $display("FAIL async_pre_write: got %h expected 66", a_data); end
        tick();
        wr_en = 1'b0;
        nvec++; if (a_data !== 8'h77) begin nerr++; $display("FAIL async_post_write: got %h expected 77", a_data); end
    endtask

    // Reset clears the read register but not the stored word (unless the clear walk runs).
    task automatic test_reset_keeps_mem();
        int n;
        logic [7:0] exp;
`ifdef RAM_DUAL_INIT_CLEAR_EN
        exp = 8'h00;
`else
        exp = 8'h5A;
`endif
        idle();
        rst = 1'b1;
        tick();
        nvec++; if (so_data !== 8'h00) begin nerr++; $display("FAIL rst2_data: got %h expected 00", so_data); end
        nvec++; if (so_valid !== 1'b0) begin nerr++; $display("FAIL rst2_valid: got %b expected 0", so_valid); end
        rst = 1'b0;
        wait_not_busy(n);
        rd_en = 1'b1; rd_addr = 3'd3;
        tick();
        rd_en = 1'b0;
        nvec++; if (so_data !== exp) begin nerr++; $display("FAIL rst2_mem: got %h expected %h", so_data, exp); end
    endtask

`ifdef RAM_DUAL_INIT_CLEAR_EN
    task automatic test_init_clear();
        int n;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 16'h4040 + 16'(i); wr_be = 2'b11;
            tick();
        end
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        while (so_busy && n < 40) begin
            wr_en = (n == 2); wr_addr = 3'd0; wr_data = 16'h00EE; wr_be = 2'b11;
            rd_en = 1'b1; rd_addr = 3'd0;
            if (n == 3) begin
                nvec++; if (a_valid !== 1'b0) begin nerr++; $display("FAIL init_async_valid: got %b expected 0", a_valid); end
            end
            tick();
            n++;
        end
        idle();
        nvec++; if (n != 8) begin nerr++; $display("FAIL init_busy_len: got %0d expected 8", n); end
        nvec++; if (so_valid !== 1'b0) begin nerr++; $display("FAIL init_rd_ignored: got %b expected 0", so_valid); end
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1; rd_addr = 3'(i);
            tick();
            nvec++; if (so_data !== 8'h00 || w_data !== 16'h0000) begin
                nerr++; $display("FAIL init_zero_%0d: got %h/%h expected 00/0000", i, so_data, w_data);
            end
        end
        idle();
    endtask

    task automatic test_init_restart();
        int n;
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        nvec++; if (so_busy !== 1'b1) begin nerr++; $display("FAIL restart_mid_busy: got %b expected 1", so_busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_not_busy(n);
        nvec++; if (n != 8) begin nerr++; $display("FAIL restart_busy_len: got %0d expected 8", n); end
    endtask
`endif

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_basic();
        test_byte_enable();
        test_rdw();
        test_independent();
        test_async();
        test_reset_keeps_mem();
`ifdef RAM_DUAL_INIT_CLEAR_EN
        test_init_clear();
        test_init_restart();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
